// File: rtl/simd_sequencer_pkg.sv
// Shared definitions for the SIMD program sequencer and its neighbours.
//   OPCODE_WIDTH / OP_SEL_WIDTH : instruction field widths shared with the decoder
//   OP_*                        : opcode encodings (opcode sits in the instruction MSBs)
//   seq_state_t                 : sequencer state encoding
package simd_sequencer_pkg;

   localparam int OPCODE_WIDTH = 3;
   localparam int OP_SEL_WIDTH = 2;

   localparam logic [OPCODE_WIDTH-1:0] OP_ADD     = 3'b000;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB     = 3'b001;
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL     = 3'b010;
   localparam logic [OPCODE_WIDTH-1:0] OP_DOT_SH  = 3'b011;
   localparam logic [OPCODE_WIDTH-1:0] OP_DOT_ACC = 3'b100;
   localparam logic [OPCODE_WIDTH-1:0] OP_PASS    = 3'b101;
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT    = 3'b110;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      EXEC  = 3'd3,
      WB    = 3'd4,
      FIN   = 3'd5
   } seq_state_t;

   function automatic logic is_halt(input logic [OPCODE_WIDTH-1:0] op);
      return op == OP_HALT;
   endfunction

endpackage

// File: rtl/simd_sequencer.sv
// Start/done controlled fetch-execute sequencer for the SIMD datapath.
// Fetches prog_len instructions from prog_base onward, latches each into ir
// for the decoder and strobes the operand-read and write-back phases.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : single-cycle control pulses from the host
//   prog_base, prog_len : program window, sampled on an accepted start
//   ins_addr, ins_en    : instruction memory address (pc) and read enable
//   instruction         : instruction memory read data (RD_LAT cycles after ins_en)
//   ir                  : latched instruction feeding the decoder
//   exec_phase          : operand-read cycle, ir valid
//   wb_phase            : write-back cycle, ANDed with decoder write_en upstream
//   busy, done          : program in progress / one-cycle completion pulse
//   instr_count         : instructions retired in the current or last program
//
// state | meaning
// IDLE  | waiting for start
// FETCH | ins_en high, address = pc
// WAIT  | memory latency; capture ir when the counter has expired
// EXEC  | operand read; HALT ends the program here
// WB    | write-back; retire, then next fetch or finish
// FIN   | done pulse, back to IDLE
module simd_sequencer #(
   parameter int INS_ADDR_WIDTH = 10,
   parameter int ADDR_WIDTH     = 10,
   parameter int OPCODE_WIDTH   = 3,
   parameter int RD_LAT         = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                abort,
   input  logic [INS_ADDR_WIDTH-1:0]           prog_base,
   input  logic [INS_ADDR_WIDTH:0]             prog_len,
   output logic [INS_ADDR_WIDTH-1:0]           ins_addr,
   output logic                                ins_en,
   input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] instruction,
   output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] ir,
   output logic                                exec_phase,
   output logic                                wb_phase,
   output logic                                busy,
   output logic                                done,
   output logic [INS_ADDR_WIDTH:0]             instr_count
);

   import simd_sequencer_pkg::*;

   localparam int IW = OPCODE_WIDTH + 3*ADDR_WIDTH;
   localparam int CW = INS_ADDR_WIDTH + 1;

   seq_state_t                 state;
   logic [INS_ADDR_WIDTH-1:0]  pc;
   logic [CW-1:0]              len_q;
   logic [1:0]                 wait_cnt;
   logic                       exec_q;
   logic                       wb_q;
   logic [OPCODE_WIDTH-1:0]    ir_op;

   assign ir_op    = ir[IW-1 -: OPCODE_WIDTH];
   assign ins_addr = pc;

   // An abort kills the strobe in the very cycle it arrives, so a write-back
   // already underway never reaches the datapath.
   assign exec_phase = exec_q & ~abort;
   assign wb_phase   = wb_q & ~abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= '0;
         len_q       <= '0;
         wait_cnt    <= '0;
         ir          <= '0;
         instr_count <= '0;
         ins_en      <= 1'b0;
         exec_q      <= 1'b0;
         wb_q        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         ins_en <= 1'b0;
         exec_q <= 1'b0;
         wb_q   <= 1'b0;
         done   <= 1'b0;
         if (abort && busy) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     instr_count <= '0;
                     if (prog_len != '0) begin
                        len_q  <= prog_len;
                        pc     <= prog_base;
                        state  <= FETCH;
                        ins_en <= 1'b1;
                        busy   <= 1'b1;
                     end else begin
                        state <= FIN;
                        done  <= 1'b1;
                     end
                  end
               end
               FETCH: begin
                  state    <= WAIT;
                  wait_cnt <= 2'(RD_LAT - 1);
               end
               WAIT: begin
                  if (wait_cnt == 2'd0) begin
                     ir     <= instruction;
                     state  <= EXEC;
                     exec_q <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt - 2'd1;
                  end
               end
               EXEC: begin
                  // HALT is not retired and skips write-back.
                  if (is_halt(ir_op)) begin
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= WB;
                     wb_q  <= 1'b1;
                  end
               end
               WB: begin
                  instr_count <= instr_count + CW'(1);
                  if (instr_count + CW'(1) == len_q) begin
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     pc     <= pc + INS_ADDR_WIDTH'(1);
                     state  <= FETCH;
                     ins_en <= 1'b1;
                  end
               end
               FIN: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_simd_sequencer.sv
// Bench for simd_sequencer: three instances at RD_LAT 1, 2 and 3, each with
// its own latency-accurate instruction memory, checked cycle by cycle against
// a schedule computed from the per-instruction timing rules.
module tb_simd_sequencer;
   import simd_sequencer_pkg::*;

   localparam int IAW  = 10;
   localparam int AW   = 10;
   localparam int OW   = 3;
   localparam int IW   = OW + 3*AW;
   localparam int CW   = IAW + 1;
   localparam int NI   = 3;
   localparam int MAXC = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst;
   logic [NI-1:0]           start, abort;
   logic [NI-1:0][IAW-1:0]  prog_base;
   logic [NI-1:0][CW-1:0]   prog_len;
   logic [NI-1:0][IAW-1:0]  ins_addr;
   logic [NI-1:0]           ins_en;
   logic [NI-1:0][IW-1:0]   instruction;
   logic [NI-1:0][IW-1:0]   ir;
   logic [NI-1:0]           exec_phase, wb_phase, busy, done;
   logic [NI-1:0][CW-1:0]   instr_count;

   logic [IW-1:0] mem [1024];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [IW-1:0] pipe [3];
      simd_sequencer #(
         .INS_ADDR_WIDTH(IAW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW), .RD_LAT(g + 1)
      ) u_dut (
         .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]),
         .prog_base(prog_base[g]), .prog_len(prog_len[g]),
         .ins_addr(ins_addr[g]), .ins_en(ins_en[g]), .instruction(instruction[g]),
         .ir(ir[g]), .exec_phase(exec_phase[g]), .wb_phase(wb_phase[g]),
         .busy(busy[g]), .done(done[g]), .instr_count(instr_count[g])
      );
      // Read data appears RD_LAT edges after an enabled fetch; otherwise junk.
      always @(posedge clk) begin
         pipe[0] <= ins_en[g] ? mem[ins_addr[g]] : IW'({$urandom, $urandom});
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign instruction[g] = pipe[g];
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Expected per-cycle schedule, cycle 0 = cycle in which start is driven.
   bit            e_en   [MAXC];
   bit            e_ex   [MAXC];
   bit            e_wb   [MAXC];
   bit            e_busy [MAXC];
   bit            e_done [MAXC];
   int            e_addr [MAXC];
   logic [IW-1:0] e_ir   [MAXC];

   function automatic logic [IW-1:0] rand_word(input int op);
      logic [IW-1:0] w;
      w = IW'({$urandom, $urandom});
      w[IW-1 -: OW] = OW'(op);
      return w;
   endfunction

   task automatic set_op(input int a, input int op);
      mem[a][IW-1 -: OW] = OW'(op);
   endtask

   task automatic run_prog(input int g, input int base, input int len,
                           input int abort_at, input int restart_at);
      int L, per, done_c, retired, last_c, f, ex, a, aborted;
      logic [OW-1:0] op;
      L = g + 1;
      per = L + 3;
      for (int c = 0; c < MAXC; c++) begin
         e_en[c] = 0; e_ex[c] = 0; e_wb[c] = 0; e_busy[c] = 0; e_done[c] = 0;
         e_addr[c] = 0; e_ir[c] = '0;
      end
      done_c = 1;
      retired = 0;
      for (int k = 0; k < len; k++) begin
         f  = 1 + k * per;
         a  = (base + k) % 1024;
         ex = f + L + 1;
         e_en[f] = 1;
         e_addr[f] = a;
         e_ex[ex] = 1;
         e_ir[ex] = mem[a];
         op = mem[a][IW-1 -: OW];
         if (op == OP_HALT) begin
            done_c = ex + 1;
            break;
         end
         e_wb[ex + 1] = 1;
         retired = k + 1;
         done_c = ex + 2;
      end
      for (int c = 1; c < done_c; c++) e_busy[c] = 1;
      e_done[done_c] = 1;
      aborted = (abort_at >= 1 && abort_at < done_c) ? 1 : 0;
      if (aborted != 0) begin
         retired = 0;
         for (int c = 0; c < abort_at; c++) if (e_wb[c]) retired++;
         e_done[done_c] = 0;
         e_ex[abort_at] = 0;
         e_wb[abort_at] = 0;
         for (int c = abort_at + 1; c < MAXC; c++) begin
            e_en[c] = 0; e_ex[c] = 0; e_wb[c] = 0; e_busy[c] = 0;
         end
         last_c = abort_at + 2;
      end else begin
         last_c = done_c + 1;
      end
      // A second start is only meaningful while busy or in FIN.
      if (restart_at > done_c || (aborted != 0 && restart_at > abort_at)) restart_at = -1;

      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         start[g]     = (c == 0) || (c == restart_at);
         prog_base[g] = (c == 0) ? IAW'(base) : IAW'($urandom);
         prog_len[g]  = (c == 0) ? CW'(len) : CW'($urandom_range(1, 2047));
         abort[g]     = (c == abort_at);
         #1;
         chk($sformatf("ctl g%0d b%0d c%0d", g, base, c),
             64'({ins_en[g], exec_phase[g], wb_phase[g], busy[g], done[g]}),
             64'({e_en[c], e_ex[c], e_wb[c], e_busy[c], e_done[c]}));
         if (e_en[c])
            chk($sformatf("addr g%0d c%0d", g, c), 64'(ins_addr[g]), 64'(e_addr[c]));
         if (e_ex[c])
            chk($sformatf("ir g%0d c%0d", g, c), 64'(ir[g]), 64'(e_ir[c]));
      end
      start[g] = 1'b0;
      abort[g] = 1'b0;
      if (len != 0)
         chk($sformatf("count g%0d b%0d", g, base), 64'(instr_count[g]), 64'(retired));
   endtask

   initial begin
      int g, base, len, ab, rs;
      rst = 1'b1;
      start = '0;
      abort = '0;
      prog_base = '0;
      prog_len = '0;
      for (int i = 0; i < 1024; i++) begin
         int op;
         op = $urandom_range(0, 6);
         if (op == 6) op = 7;
         mem[i] = rand_word(op);
      end

      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst ctl g%0d", i),
             64'({ins_en[i], exec_phase[i], wb_phase[i], busy[i], done[i]}), 64'(0));
         chk($sformatf("rst data g%0d", i),
             64'({ins_addr[i], ir[i], instr_count[i]}), 64'(0));
      end
      rst = 1'b0;

      // Basic run, undefined opcode in the middle is retired.
      set_op(5, 0); set_op(6, 7); set_op(7, 2);
      run_prog(0, 5, 3, -1, -1);
      // HALT in the second slot; third word never fetched.
      set_op(20, 0); set_op(21, 6); set_op(22, 0);
      run_prog(0, 20, 3, -1, -1);
      run_prog(0, 3, 0, -1, -1);
      run_prog(0, 1023, 2, -1, -1);
      // Abort during the second instruction's wait, RD_LAT=3.
      run_prog(2, 40, 4, 9, -1);
      run_prog(0, 50, 2, -1, 3);
      run_prog(1, 60, 2, -1, 11);
      run_prog(1, 70, 2, 0, -1);
      // Abort landing on the last write-back.
      run_prog(0, 80, 2, 8, -1);
      run_prog(1, 100, 3, -1, -1);

      // Reset asserted while in EXEC.
      @(negedge clk);
      start[0] = 1'b1; prog_base[0] = 10'd9; prog_len[0] = 11'd3;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("exec before rst", 64'(exec_phase[0]), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst ctl", 64'({ins_en[0], exec_phase[0], wb_phase[0], busy[0], done[0]}), 64'(0));
      chk("midrst data", 64'({ins_addr[0], ir[0], instr_count[0]}), 64'(0));
      rst = 1'b0;
      run_prog(0, 200, 2, -1, -1);

      for (int r = 0; r < 14; r++) begin
         g    = $urandom_range(0, NI - 1);
         base = $urandom_range(0, 1023);
         len  = $urandom_range(1, 7);
         if ($urandom_range(0, 3) == 0)
            set_op((base + $urandom_range(0, len - 1)) % 1024, 6);
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len * (g + 4)) : -1;
         rs = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len * (g + 4)) : -1;
         run_prog(g, base, len, ab, rs);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/simd_sequencer.md
Name: simd_sequencer

Overview:
- Program sequencer for the SIMD datapath. It replaces the free-running, half_clk-gated PC with a start/done controlled fetch–execute loop.
- Fetches instructions from instruction memory starting at a programmable base and latches each one into an instruction register that feeds the decoder.
- Generates per-phase strobes: operand-read phase and write-back phase, which gates the decoder's write_en.
- Stops on program length exhausted, HALT opcode or abort. Sits between the host/top-level control and the decoder / instruction BRAM.

Parameters:
- INS_ADDR_WIDTH, 10, instruction memory address width.
- ADDR_WIDTH, 10, data BRAM address field width inside the instruction word.
- OPCODE_WIDTH, 3, opcode field width (shared package constant; parameter mirrors it).
- RD_LAT, 1, instruction memory read latency in cycles (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; launches a program when idle.
- abort  in  1  single-cycle pulse; terminates a running program.
- prog_base  in  INS_ADDR_WIDTH  first instruction address; sampled on accepted start.
- prog_len  in  INS_ADDR_WIDTH+1  instruction count; sampled on accepted start.
- ins_addr  out  INS_ADDR_WIDTH  instruction memory address (pc).
- ins_en  out  1  instruction memory read enable.
- instruction  in  OPCODE_WIDTH+3*ADDR_WIDTH  instruction memory read data.
- ir  out  OPCODE_WIDTH+3*ADDR_WIDTH  latched instruction to decoder.
- exec_phase  out  1  operand-read cycle; ir is valid.
- wb_phase  out  1  write-back cycle; top ANDs this with the decoder's write_en.
- busy  out  1  program in progress.
- done  out  1  single-cycle completion pulse.
- instr_count  out  INS_ADDR_WIDTH+1  instructions retired in the current or last program.

Behaviour:
- Reset: all outputs 0, state IDLE, pc=0, ir=0, instr_count=0. Applies at any point mid-program; no done pulse results.
- States: IDLE, FETCH, WAIT, EXEC, WB, FIN.
- IDLE:
  - start with prog_len≠0: latch base/len, pc<=prog_base, instr_count<=0, go to FETCH; busy rises next cycle.
  - start with prog_len=0: go to FIN; done is asserted on the cycle after start, with no fetch.
- FETCH: ins_en=1 for one cycle, ins_addr=pc. Then go to WAIT with wait counter = RD_LAT-1. If RD_LAT=1, the counter is already expired.
- WAIT: count down. When expired, capture instruction into ir and go to EXEC.
  - Per-instruction cost is RD_LAT+3 cycles (FETCH + RD_LAT-1 WAIT cycles + capture cycle + EXEC + WB).
  - With RD_LAT=1 this is 4 cycles per instruction.
- EXEC: exec_phase=1 for one cycle.
  - If ir opcode = OP_HALT (3'b110): go to FIN. HALT is not retired and WB is skipped.
  - Otherwise go to WB.
- WB: wb_phase=1 for one cycle; instr_count++.
  - If instr_count+1 == prog_len: go to FIN.
  - Else pc<=pc+1 (wraps modulo 2^INS_ADDR_WIDTH) and go to FETCH.
- FIN: done=1 for one cycle, busy=0, go to IDLE. ir and instr_count hold their final values.
- busy=1 in FETCH, WAIT, EXEC and WB only.
- ins_addr holds pc in all states.
- Start handling:
  - start while busy or in FIN is ignored.
  - start and abort in the same IDLE cycle: start wins, because abort has no effect in IDLE.
- abort while busy: next state IDLE; exec_phase and wb_phase forced 0 that cycle; no done pulse; instr_count frozen.
- abort coinciding with the last WB: abort wins, so no done pulse. wb_phase is still suppressed.
- Opcode 3'b111 (undefined): passes through EXEC/WB and is retired. It produces no write because the decoder's write_en is 0 for it.
- Dot-product chains (3'b011 followed by 3'b100) need no special sequencing; one instruction completes per WB.

Decomposition:
- Shared package params.svh:
  - OPCODE_WIDTH and OP_SEL_WIDTH.
  - opcode localparams OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_DOT_SH=011, OP_DOT_ACC=100, OP_PASS=101, OP_HALT=110.
  - seq_state_t enum (IDLE, FETCH, WAIT, EXEC, WB, FIN).
- Single flat module, no sub-module. The RD_LAT wait counter is small enough to stay inline.

Test Plan:
- Basic run: prog_base=5, prog_len=3, RD_LAT=1 → ins_addr 5,6,7 each with a 1-cycle ins_en; wb_phase at cycles 4, 8, 12 after start; done at cycle 13; instr_count=3.
- HALT: program ADD, HALT, ADD with prog_len=3 → one wb_phase pulse; done after the HALT EXEC; instr_count=1; address 7 never fetched.
- Boundaries:
  - prog_len=0 → done the cycle after start, no ins_en.
  - prog_base=1023, len=2 → addresses 1023 then 0.
- Abort during the WAIT of the 2nd instruction (RD_LAT=3) → IDLE next cycle, no done, instr_count=1, no further ins_en.
- Start while busy is ignored. Reset asserted mid-EXEC → all outputs 0 the next cycle, and a fresh start works normally.
- RD_LAT=2 → ir equals the memory word at pc, captured 2 cycles after FETCH; 5 cycles per instruction.
